// File: rtl/lcd_token_fifo.sv
// rtl/lcd_token_fifo.sv - token FIFO feeding the LCD entry register
// Pops are triggered by the rising edge of rd; overflow and underflow are sticky until reset.
module lcd_token_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     full,
    input  logic                     rd,
    output logic [WIDTH-1:0]         entry_out,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] entry_q, entry_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_q, rd_d;

    logic pop_req;
    logic do_pop;
    logic accept;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign entry_out = entry_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // A full FIFO still takes a write when a pop frees a slot at the same edge.
    assign pop_req = rd && !rd_q;
    assign do_pop  = pop_req && !empty;
    assign accept  = wr && (!full || do_pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        entry_d     = entry_q;
        overflow_d  = overflow_q || (wr && !accept);
        underflow_d = underflow_q || (pop_req && empty);
        rd_d        = rd;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            entry_d  = mem_q[rd_ptr_q];
        end
        if (accept && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !accept) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            entry_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            // Treat rd as already high so a level held through reset cannot pop.
            rd_q        <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            entry_q     <= entry_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_q        <= rd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end
endmodule

// File: tb/tb_lcd_token_fifo.sv
// tb/tb_lcd_token_fifo.sv - self-checking bench for lcd_token_fifo
// Vector table, directed corner sequences and random traffic against a queue model.
module tb_lcd_token_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             wr = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             rd = 1'b0;
    logic             full, empty, overflow, underflow;
    logic [WIDTH-1:0] entry_out;
    logic [2:0]       count;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_entry;
    logic             m_ovf, m_unf, m_prev_rd;

    typedef struct {
        logic             rst;
        logic             wr;
        logic [WIDTH-1:0] data;
        logic             rd;
        int               e_count;
        logic [WIDTH-1:0] e_entry;
        logic             e_full;
        logic             e_empty;
        logic             e_ovf;
        logic             e_unf;
    } vec_t;

    vec_t vecs[$];

    lcd_token_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .wr(wr), .data_in(data_in), .full(full),
        .rd(rd), .entry_out(entry_out), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic model_update(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic rr);
        logic pop_req, was_empty, was_full, popping, acc;
        if (r) begin
            mq.delete();
            m_entry = '0; m_ovf = 1'b0; m_unf = 1'b0; m_prev_rd = 1'b1;
        end else begin
            pop_req   = rr && !m_prev_rd;
            m_prev_rd = rr;
            was_empty = (mq.size() == 0);
            was_full  = (mq.size() == DEPTH);
            popping   = pop_req && !was_empty;
            if (pop_req && was_empty) m_unf = 1'b1;
            acc = w && (!was_full || popping);
            if (w && !acc) m_ovf = 1'b1;
            if (popping) m_entry = mq.pop_front();
            if (acc) mq.push_back(d);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic rr);
        reset = r; wr = w; data_in = d; rd = rr;
        @(posedge clock);
        #1;
        model_update(r, w, d, rr);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".count"}, int'(count), mq.size());
        chk({tag, ".entry"}, int'(entry_out), int'(m_entry));
        chk({tag, ".full"}, int'(full), int'(mq.size() == DEPTH));
        chk({tag, ".empty"}, int'(empty), int'(mq.size() == 0));
        chk({tag, ".ovf"}, int'(overflow), int'(m_ovf));
        chk({tag, ".unf"}, int'(underflow), int'(m_unf));
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic rr,
                                input int c, input logic [WIDTH-1:0] e, input logic o, input logic u);
        vec_t v;
        v.rst = r; v.wr = w; v.data = d; v.rd = rr;
        v.e_count = c; v.e_entry = e; v.e_full = (c == DEPTH); v.e_empty = (c == 0);
        v.e_ovf = o; v.e_unf = u;
        return v;
    endfunction

    initial begin
        // basic write/pop latency
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 16'h00A5, 0, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 16'h1234, 0, 2, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 16'hFFFF, 0, 3, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 2, 16'h00A5, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 2, 16'h00A5, 0, 0));
        // overflow and ordered drain
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0001, 0, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0002, 0, 2, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0003, 0, 3, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0004, 0, 4, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0005, 0, 4, 16'h0000, 1, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 3, 16'h0001, 1, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 3, 16'h0001, 1, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 2, 16'h0002, 1, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 2, 16'h0002, 1, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 1, 16'h0003, 1, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0003, 1, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0004, 1, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0004, 1, 0));
        // underflow, then underflow with a same-cycle write (no bypass)
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0004, 1, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0004, 1, 1));
        vecs.push_back(mk(0, 1, 16'h0777, 1, 1, 16'h0004, 1, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0004, 1, 1));

        m_entry = '0; m_ovf = 1'b0; m_unf = 1'b0; m_prev_rd = 1'b1;

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].rd);
            chk({t, ".count"}, int'(count), vecs[i].e_count);
            chk({t, ".entry"}, int'(entry_out), int'(vecs[i].e_entry));
            chk({t, ".full"}, int'(full), int'(vecs[i].e_full));
            chk({t, ".empty"}, int'(empty), int'(vecs[i].e_empty));
            chk({t, ".ovf"}, int'(overflow), int'(vecs[i].e_ovf));
            chk({t, ".unf"}, int'(underflow), int'(vecs[i].e_unf));
        end

        // rd level held for 10 cycles pops exactly once
        step(1, 0, 0, 0);
        step(0, 1, 16'h0011, 0);
        step(0, 1, 16'h0022, 0);
        step(0, 1, 16'h0033, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        chk("hold.count", int'(count), 2);
        chk("hold.entry", int'(entry_out), 16'h0011);
        step(0, 0, 0, 0);

        // write and pop together while full
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, WIDTH'(16'h0010 + i), 0);
        chk("full.before", int'(full), 1);
        step(0, 1, 16'hBEEF, 1);
        chk("fullwp.count", int'(count), 4);
        chk("fullwp.ovf", int'(overflow), 0);
        chk("fullwp.entry", int'(entry_out), 16'h0010);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            step(0, 0, 0, 1);
        end
        chk("fullwp.last", int'(entry_out), 16'hBEEF);
        chk("fullwp.drained", int'(empty), 1);

        // reset with rd held high: no pop on release, first write accepted
        step(1, 0, 0, 1);
        step(0, 1, 16'h0A0A, 1);
        step(0, 1, 16'h0B0B, 1);
        step(0, 1, 16'h0C0C, 1);
        chk("rsthold.count", int'(count), 3);
        step(1, 1, 16'hDEAD, 1);
        chk("rst.count", int'(count), 0);
        chk("rst.empty", int'(empty), 1);
        chk("rst.entry", int'(entry_out), 0);
        chk("rst.flags", int'({overflow, underflow}), 0);
        step(0, 1, 16'h0055, 1);
        chk("postrst.count", int'(count), 1);
        chk("postrst.unf", int'(underflow), 0);
        chk("postrst.entry", int'(entry_out), 0);

        // random traffic against the queue model
        step(1, 0, 0, 0);
        cmp_model("rnd_init");
        for (int i = 0; i < 600; i++) begin
            logic r, w, rr;
            r  = ($urandom_range(0, 79) == 0);
            w  = ($urandom_range(0, 99) < 55);
            rr = ($urandom_range(0, 99) < 45);
            step(r, w, WIDTH'($urandom), rr);
            cmp_model($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
